// File: rtl/convolver_pkg.sv
// Shared sizing helpers for the convolver datapath: product count, adder-tree depth,
// accumulator width and the multiplier-bus lane layout.
package convolver_pkg;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int n_products(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

    // Growth of clog2(N) bits is enough headroom that the tree can never overflow.
    function automatic int sum_width(input int data_width, input int kernel_size);
        return data_width + clog2(n_products(kernel_size));
    endfunction

    function automatic int stage_count(input int kernel_size);
        int depth;
        depth = clog2(n_products(kernel_size));
        return (depth < 1) ? 1 : depth;
    endfunction

    // Number of partial sums held by tree level `stage` (ceil(n / 2**(stage+1))).
    function automatic int level_count(input int n, input int stage);
        return (n + (1 << (stage + 1)) - 1) >> (stage + 1);
    endfunction

    // Lane i of the multiplier bus lives at bits [i*width +: width].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/reducer_stage.sv
// One registered level of the adder tree: adds neighbouring pairs, forwards an odd
// trailing element untouched, and carries a valid bit. Holds everything while enable=0.
module reducer_stage #(
    parameter int IN_COUNT = 2,
    parameter int WIDTH    = 36
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 in_valid,
    input  logic [IN_COUNT*WIDTH-1:0]            data_in,
    output logic                                 out_valid,
    output logic [((IN_COUNT+1)/2)*WIDTH-1:0]    data_out
);

    localparam int OUT_COUNT = (IN_COUNT + 1) / 2;

    logic [OUT_COUNT*WIDTH-1:0] next_data;

    for (genvar i = 0; i < OUT_COUNT; i++) begin : g_pair
        if (2 * i + 1 < IN_COUNT) begin : g_add
            assign next_data[i*WIDTH +: WIDTH] = data_in[2*i*WIDTH +: WIDTH]
                                               + data_in[(2*i+1)*WIDTH +: WIDTH];
        end else begin : g_pass
            assign next_data[i*WIDTH +: WIDTH] = data_in[2*i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (enable) begin
            out_valid <= in_valid;
            data_out  <= next_data;
        end
    end

endmodule

// File: rtl/product_reducer.sv
// Pipelined adder tree reducing KERNEL_SIZE**2 signed products to one sum, with a
// single global advance so the whole pipe stalls together under backpressure.
module product_reducer
    import convolver_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int SATURATE    = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [n_products(KERNEL_SIZE)*DATA_WIDTH-1:0] products,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_WIDTH-1:0]                         sum
);

    localparam int N         = n_products(KERNEL_SIZE);
    localparam int STAGES    = stage_count(KERNEL_SIZE);
    localparam int SUM_WIDTH = sum_width(DATA_WIDTH, KERNEL_SIZE);

    localparam logic signed [DATA_WIDTH-1:0] MAX_OUT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_OUT = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_WIDTH-1:0]  MAX_EXT = SUM_WIDTH'(MAX_OUT);
    localparam logic signed [SUM_WIDTH-1:0]  MIN_EXT = SUM_WIDTH'(MIN_OUT);

    logic                       adv;
    logic [N*SUM_WIDTH-1:0]     lanes_ext;
    logic signed [SUM_WIDTH-1:0] final_sum;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] lane;
        assign lane = products[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
        assign lanes_ext[i*SUM_WIDTH +: SUM_WIDTH] = SUM_WIDTH'(lane);
    end

    // Each level feeds the next; level 0 takes the sign-extended lanes directly.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int IN_COUNT  = (s == 0) ? N : level_count(N, s - 1);
        localparam int OUT_COUNT = level_count(N, s);

        logic [IN_COUNT*SUM_WIDTH-1:0]  din;
        logic [OUT_COUNT*SUM_WIDTH-1:0] q;
        logic                           v_in;
        logic                           v;

        if (s == 0) begin : g_first
            assign din  = lanes_ext;
            assign v_in = in_valid;
        end else begin : g_next
            assign din  = g_stage[s-1].q;
            assign v_in = g_stage[s-1].v;
        end

        reducer_stage #(
            .IN_COUNT (IN_COUNT),
            .WIDTH    (SUM_WIDTH)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .enable    (adv),
            .in_valid  (v_in),
            .data_in   (din),
            .out_valid (v),
            .data_out  (q)
        );
    end

    assign final_sum = g_stage[STAGES-1].q;
    assign out_valid = g_stage[STAGES-1].v;

    always_comb begin
        sum = final_sum[DATA_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (final_sum > MAX_EXT) begin
                sum = MAX_OUT;
            end else if (final_sum < MIN_EXT) begin
                sum = MIN_OUT;
            end
        end
    end

endmodule

// File: tb/tb_product_reducer.sv
// Self-checking bench for product_reducer: scoreboard of exact sums plus directed
// latency/saturation/reset cases, and small side instances for other kernel sizes.
module tb_product_reducer;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [9*32-1:0]  products;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      sum;

    logic             in_ready_wrap;
    logic             out_valid_wrap;
    logic [31:0]      sum_wrap;

    logic             in_valid_k1, in_ready_k1, out_valid_k1;
    logic [31:0]      products_k1, sum_k1;
    logic             in_valid_k5, in_ready_k5, out_valid_k5;
    logic [25*32-1:0] products_k5;
    logic [31:0]      sum_k5;

    int     testsRun    = 0;
    int     testsFailed = 0;
    int     popCount    = 0;
    longint expQ[$];
    bit     stallPrev   = 1'b0;
    logic [31:0] heldSum = '0;

    product_reducer #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .products(products),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum));

    product_reducer #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_wrap), .products(products),
        .out_valid(out_valid_wrap), .out_ready(out_ready), .sum(sum_wrap));

    product_reducer #(.DATA_WIDTH(32), .KERNEL_SIZE(1), .SATURATE(1)) dut_k1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_k1), .in_ready(in_ready_k1), .products(products_k1),
        .out_valid(out_valid_k1), .out_ready(1'b1), .sum(sum_k1));

    product_reducer #(.DATA_WIDTH(32), .KERNEL_SIZE(5), .SATURATE(1)) dut_k5 (
        .clk(clk), .reset(reset), .in_valid(in_valid_k5), .in_ready(in_ready_k5), .products(products_k5),
        .out_valid(out_valid_k5), .out_ready(1'b1), .sum(sum_k5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact mathematical sum of the nine signed lanes.
    function automatic longint modelSum(input logic [9*32-1:0] vec);
        longint acc;
        acc = 0;
        for (int i = 0; i < 9; i++) acc += longint'($signed(vec[i*32 +: 32]));
        return acc;
    endfunction

    function automatic logic [31:0] saturate(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    function automatic logic [31:0] truncate(input longint v);
        return v[31:0];
    endfunction

    function automatic logic [9*32-1:0] fillVec(input logic [31:0] value);
        logic [9*32-1:0] vec;
        for (int i = 0; i < 9; i++) vec[i*32 +: 32] = value;
        return vec;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents a vector and holds it until the handshake completes; returns #1 after that edge.
    task automatic applyStimulus(input logic [9*32-1:0] vec);
        bit accepted;
        int tries;
        accepted = 1'b0;
        tries    = 0;
        in_valid = 1'b1;
        products = vec;
        while (!accepted && tries < 64) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic runDirected(input string name, input logic [9*32-1:0] vec,
                               input logic [31:0] expSat, input logic [31:0] expWrap);
        int cycles;
        applyStimulus(vec);
        cycles = 1;
        while (!out_valid && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({name, "_latency"}, 64'(cycles), 64'd4);
        checkOutput({name, "_sum"}, 64'(sum), 64'(expSat));
        checkOutput({name, "_wrap"}, 64'(sum_wrap), 64'(expWrap));
        @(posedge clk);
        #1;
        checkOutput({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    // Scoreboard: every pop must match the oldest accepted vector; stalls must hold output.
    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
            stallPrev = 1'b0;
        end else begin
            checkOutput("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            checkOutput("in_ready_wrap_rule", 64'(in_ready_wrap), 64'(!out_valid_wrap || out_ready));
            if (stallPrev) begin
                checkOutput("stall_valid_hold", 64'(out_valid), 64'd1);
                checkOutput("stall_sum_hold", 64'(sum), 64'(heldSum));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    longint expected;
                    expected = expQ.pop_front();
                    popCount++;
                    checkOutput("sb_sum_sat", 64'(sum), 64'(saturate(expected)));
                    checkOutput("sb_sum_wrap", 64'(sum_wrap), 64'(truncate(expected)));
                end
            end
            if (in_valid && in_ready) expQ.push_back(modelSum(products));
            stallPrev = out_valid && !out_ready;
            heldSum   = sum;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9*32-1:0] altVec;
        logic [9*32-1:0] rndVec;
        int popsBefore;
        int guard;
        int cycles;

        reset       = 1'b1;
        in_valid    = 1'b0;
        products    = '0;
        out_ready   = 1'b1;
        in_valid_k1 = 1'b0;
        products_k1 = '0;
        in_valid_k5 = 1'b0;
        products_k5 = '0;

        #3;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_sum", 64'(sum), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_k5_valid", 64'(out_valid_k5), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        runDirected("ones", fillVec(32'd1), 32'd9, 32'd9);

        for (int i = 0; i < 9; i++) altVec[i*32 +: 32] = (i % 2 == 0) ? 32'd5 : 32'hFFFF_FFFB;
        runDirected("alternating", altVec, 32'd5, 32'd5);
        runDirected("minus_one", fillVec(32'hFFFF_FFFF), 32'hFFFF_FFF7, 32'hFFFF_FFF7);
        runDirected("max_pos", fillVec(32'h7FFF_FFFF), 32'h7FFF_FFFF, 32'h7FFF_FFF7);
        runDirected("max_neg", fillVec(32'h8000_0000), 32'h8000_0000, 32'h8000_0000);

        popsBefore = popCount;
        fork
            begin
                for (int v = 0; v < 20; v++) begin
                    for (int i = 0; i < 9; i++) rndVec[i*32 +: 32] = $urandom;
                    applyStimulus(rndVec);
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
                checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        guard = 0;
        while (expQ.size() != 0 && guard < 64) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("stream_count", 64'(popCount - popsBefore), 64'd20);
        checkOutput("stream_drained", 64'(expQ.size()), 64'd0);

        for (int v = 0; v < 5; v++) applyStimulus(fillVec(32'(v + 3)));
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
        checkOutput("async_reset_sum", 64'(sum), 64'd0);
        checkOutput("async_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("no_stale_valid", 64'(out_valid), 64'd0);
        runDirected("after_reset", fillVec(32'd2), 32'd18, 32'd18);

        in_valid_k1 = 1'b1;
        products_k1 = 32'h0000_0007;
        @(negedge clk);
        checkOutput("k1_in_ready", 64'(in_ready_k1), 64'd1);
        @(posedge clk);
        #1 in_valid_k1 = 1'b0;
        cycles = 1;
        while (!out_valid_k1 && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("k1_latency", 64'(cycles), 64'd1);
        checkOutput("k1_sum", 64'(sum_k1), 64'd7);

        in_valid_k5 = 1'b1;
        for (int i = 0; i < 25; i++) products_k5[i*32 +: 32] = 32'd1;
        @(negedge clk);
        checkOutput("k5_in_ready", 64'(in_ready_k5), 64'd1);
        @(posedge clk);
        #1 in_valid_k5 = 1'b0;
        cycles = 1;
        while (!out_valid_k5 && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("k5_latency", 64'(cycles), 64'd5);
        checkOutput("k5_sum", 64'(sum_k5), 64'd25);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
